// File: rtl/imm_seq_pkg.sv
// Shared types for the immediate-load sequencer.
// State encoding and immediate-unit flag values.
package imm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO,
    WB
  } state_e;

  localparam logic FLAG_HI = 1'b1;
  localparam logic FLAG_LO = 1'b0;

endpackage

// File: rtl/imm_rr_arb2.sv
// Two-requester round-robin arbiter.
// The pointer names the requester that wins a tie.
module imm_rr_arb2
  import imm_seq_pkg::*;
#(
  parameter logic RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       ptr
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // After a grant the other requester wins the next tie.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && (|gnt))
      ptr_d = gnt[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr_q <= RR_INIT;
    else
      ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/imm_seq_ctrl.sv
// Sequences a 16-bit constant load through an 8-bit immediate unit.
// Option: IMM_SEQ_SKIP_ZERO_EN skips the HI step when data[15:8] is zero.
module imm_seq_ctrl
  import imm_seq_pkg::*;
#(
  parameter int   RF_AW   = 3,
  parameter logic RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [15:0]      req_data0,
  input  logic [15:0]      req_data1,
  input  logic [RF_AW-1:0] req_dst0,
  input  logic [RF_AW-1:0] req_dst1,
  output logic [1:0]       req_ready,
  output logic             imm_en,
  output logic             flag,
  output logic [7:0]       imm,
  input  logic [15:0]      imm_in,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_addr,
  output logic [15:0]      rf_wdata,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [15:0]      data_q, data_d;
  logic [RF_AW-1:0] dst_q, dst_d;
  logic [15:0]      acc_q, acc_d;
  logic             imm_en_q, imm_en_d;
  logic             flag_q, flag_d;
  logic [7:0]       imm_q, imm_d;
  logic             rf_we_q, rf_we_d;
  logic [RF_AW-1:0] rf_addr_q, rf_addr_d;
  logic             busy_q, busy_d;

  logic [1:0] arb_req;
  logic [1:0] gnt;
  logic       ptr;
  logic       sel;

  assign arb_req = (state_q == IDLE) ? req_valid : 2'b00;

  imm_rr_arb2 #(
    .RR_INIT(RR_INIT)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (arb_req),
    .advance(|gnt),
    .gnt    (gnt),
    .ptr    (ptr)
  );

  assign sel = gnt[1] | (~gnt[0] & ptr);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dst_d   = dst_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          data_d  = sel ? req_data1 : req_data0;
          dst_d   = sel ? req_dst1 : req_dst0;
          state_d = HI;
`ifdef IMM_SEQ_SKIP_ZERO_EN
          if (data_d[15:8] == 8'h00) begin
            state_d = LO;
            acc_d   = 16'h0000;
          end
`endif
        end
      end
      HI: state_d = LO;
      LO: begin
        acc_d   = imm_in;
        state_d = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave flops.
  always_comb begin
    imm_en_d  = (state_d == HI) || (state_d == LO);
    flag_d    = (state_d == HI) ? FLAG_HI : FLAG_LO;
    imm_d     = 8'h00;
    if (state_d == HI)
      imm_d = data_d[15:8];
    else if (state_d == LO)
      imm_d = data_d[7:0];
    rf_we_d   = (state_d == WB);
    rf_addr_d = (state_d == WB) ? dst_d : '0;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      dst_q     <= '0;
      acc_q     <= '0;
      imm_en_q  <= 1'b0;
      flag_q    <= 1'b0;
      imm_q     <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      dst_q     <= dst_d;
      acc_q     <= acc_d;
      imm_en_q  <= imm_en_d;
      flag_q    <= flag_d;
      imm_q     <= imm_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      busy_q    <= busy_d;
    end
  end

  assign req_ready = ((state_q == IDLE) && !reset) ? gnt : 2'b00;
  assign imm_en    = imm_en_q;
  assign flag      = flag_q;
  assign imm       = imm_q;
  assign rf_we     = rf_we_q;
  assign rf_addr   = rf_addr_q;
  assign rf_wdata  = rf_we_q ? (acc_q | imm_in) : 16'h0000;
  assign busy      = busy_q;

endmodule

// File: tb/tb_imm_seq_ctrl.sv
// Bench for imm_seq_ctrl with a behavioural immediate unit.
// A cycle model predicts grants and queues the expected writes.
module tb_imm_seq_ctrl;

  localparam int   AW      = 3;
  localparam logic TB_INIT = 1'b0;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [15:0]   req_data0, req_data1;
  logic [AW-1:0] req_dst0, req_dst1;
  logic [1:0]    req_ready;
  logic          imm_en, flag;
  logic [7:0]    imm;
  logic [15:0]   imm_in;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [15:0]   rf_wdata;
  logic          busy;

  imm_seq_ctrl #(
    .RF_AW  (AW),
    .RR_INIT(TB_INIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_data0(req_data0),
    .req_data1(req_data1),
    .req_dst0 (req_dst0),
    .req_dst1 (req_dst1),
    .req_ready(req_ready),
    .imm_en   (imm_en),
    .flag     (flag),
    .imm      (imm),
    .imm_in   (imm_in),
    .rf_we    (rf_we),
    .rf_addr  (rf_addr),
    .rf_wdata (rf_wdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Immediate unit: places the byte, result registered one cycle later.
  always @(posedge clk or posedge reset) begin
    if (reset)
      imm_in <= 16'h0000;
    else if (imm_en)
      imm_in <= flag ? {imm, 8'h00} : {8'h00, imm};
    else
      imm_in <= 16'h0000;
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int npass = 0;
  int ntotal = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input logic [15:0] d);
`ifdef IMM_SEQ_SKIP_ZERO_EN
    return (d[15:8] == 8'h00) ? 2 : 3;
`else
    return (d == d) ? 3 : 3;
`endif
  endfunction

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } exp_t;

  exp_t q[$];
  logic m_ptr = TB_INIT;
  int   m_cnt = 0;

  // Scoreboard: model grants and check every write against the queue.
  initial forever begin
    @(negedge clk);
    #2;
    if (reset) begin
      q.delete();
      m_ptr = TB_INIT;
      m_cnt = 0;
    end else begin
      logic [1:0] exp_rdy;
      logic       exp_busy;
      logic       g;
      exp_t       e;
      exp_rdy  = 2'b00;
      exp_busy = (m_cnt != 0);
      if (m_cnt != 0) begin
        m_cnt--;
      end else if (|req_valid) begin
        g       = (req_valid == 2'b11) ? m_ptr : req_valid[1];
        exp_rdy = g ? 2'b10 : 2'b01;
        m_ptr   = ~g;
        e.data  = g ? req_data1 : req_data0;
        e.addr  = g ? req_dst1 : req_dst0;
        e.due   = cyc + lat_of(e.data);
        m_cnt   = lat_of(e.data);
        q.push_back(e);
      end
      chk("sb_ready", 32'(req_ready), 32'(exp_rdy));
      chk("sb_busy", 32'(busy), 32'(exp_busy));
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("sb_we", 32'(rf_we), 32'd1);
        chk("sb_wdata", 32'(rf_wdata), 32'(e.data));
        chk("sb_waddr", 32'(rf_addr), 32'(e.addr));
      end else begin
        chk("sb_we_idle", 32'(rf_we), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_one(input logic who, input logic [15:0] d,
                         input logic [AW-1:0] a, input int lat);
    int t;
    req_valid = who ? 2'b10 : 2'b01;
    if (who) begin req_data1 = d; req_dst1 = a; end
    else begin req_data0 = d; req_dst0 = a; end
    #1 chk("one_ready", 32'(req_ready), who ? 32'd2 : 32'd1);
    tick();
    req_valid = 2'b00;
    #1 chk("one_flag1", 32'(flag), (lat == 3) ? 32'd1 : 32'd0);
    t = 1;
    while (!rf_we && t < 6) begin
      tick();
      #1 t++;
    end
    chk("one_lat", 32'(t), 32'(lat));
    chk("one_wdata", 32'(rf_wdata), 32'(d));
    tick();
  endtask

  initial begin
    logic [15:0] wd[$];
    int          wc[$];
    reset     = 1'b1;
    req_valid = 2'b00;
    req_data0 = '0;
    req_data1 = '0;
    req_dst0  = '0;
    req_dst1  = '0;
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_imm_en", 32'(imm_en), 32'd0);
    chk("rst_flag", 32'(flag), 32'd0);
    chk("rst_imm", 32'(imm), 32'd0);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_addr", 32'(rf_addr), 32'd0);
    chk("rst_wdata", 32'(rf_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    // Single load with extra traffic while busy.
    req_valid = 2'b01;
    req_data0 = 16'hA55A;
    req_dst0  = 3'd5;
    #1 chk("ld_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b11;
    req_data0 = 16'hFFFF;
    req_dst0  = 3'd1;
    #1 chk("hi_en", 32'(imm_en), 32'd1);
    chk("hi_flag", 32'(flag), 32'd1);
    chk("hi_imm", 32'(imm), 32'hA5);
    chk("hi_ready", 32'(req_ready), 32'd0);
    tick();
    req_valid = 2'b10;
    #1 chk("lo_en", 32'(imm_en), 32'd1);
    chk("lo_flag", 32'(flag), 32'd0);
    chk("lo_imm", 32'(imm), 32'h5A);
    chk("lo_ready", 32'(req_ready), 32'd0);
    tick();
    req_valid = 2'b00;
    #1 chk("wb_we", 32'(rf_we), 32'd1);
    chk("wb_addr", 32'(rf_addr), 32'd5);
    chk("wb_wdata", 32'(rf_wdata), 32'hA55A);
    chk("wb_en", 32'(imm_en), 32'd0);
    chk("wb_ready", 32'(req_ready), 32'd0);
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Reset during LO abandons the request and restores priority.
    req_valid = 2'b01;
    req_data0 = 16'h1234;
    req_dst0  = 3'd3;
    tick();
    req_valid = 2'b00;
    tick();
    reset = 1'b1;
    #1 chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_we", 32'(rf_we), 32'd0);
    chk("mrst_en", 32'(imm_en), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();

    // Contention: both valid, writes alternate.
    req_valid = 2'b11;
    req_data0 = 16'h1111;
    req_data1 = 16'h2222;
    req_dst0  = 3'd1;
    req_dst1  = 3'd2;
    #1 chk("ct_ready0", 32'(req_ready), 32'd1);
    for (int i = 0; i < 11; i++) begin
      tick();
      #1 if (rf_we) begin
        wd.push_back(rf_wdata);
        wc.push_back(cyc);
      end
    end
    req_valid = 2'b00;
    chk("ct_count", 32'(wd.size()), 32'd3);
    if (wd.size() == 3) begin
      chk("ct_w0", 32'(wd[0]), 32'h1111);
      chk("ct_w1", 32'(wd[1]), 32'h2222);
      chk("ct_w2", 32'(wd[2]), 32'h1111);
      chk("ct_gap", 32'(wc[1] - wc[0]), 32'd4);
    end
    tick();
    tick();

    // Boundary data values.
    run_one(1'b1, 16'h0000, 3'd7, 3);
    run_one(1'b0, 16'hFFFF, 3'd0, 3);
`ifdef IMM_SEQ_SKIP_ZERO_EN
    run_one(1'b1, 16'h00C3, 3'd6, 2);
`else
    run_one(1'b1, 16'h00C3, 3'd6, 3);
`endif
    tick();
    tick();
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
